fetch_unit: RTL and testbench

Parametrised instruction-fetch front end that replaces the bare program counter plus direct instruction-memory hookup of the single-cycle core. It owns the fetch PC and issues requests to instruction memory over a valid/ready handshake, tolerating any memory latency of at least one cycle. Returned words go into a DEPTH-entry prefetch queue that feeds decode. Branch/jump redirects and `clr` flush the queue, and any response still in flight for a stale request is discarded.

---
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Owns the fetch PC, issues one
// request at a time to instruction memory over valid/ready, and buffers the
// returned words in a small circular prefetch queue that feeds decode.
// Redirects and clr flush the queue; a response still in flight for a
// request made before the flush is dropped when it arrives.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              IWIDTH   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [IWIDTH-1:0]          imem_rsp_data,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [IWIDTH-1:0]          inst_data,
    output logic [XLEN-1:0]            inst_pc,
    output logic [XLEN-1:0]            pc_out,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Architectural state
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            run_q;
    logic            outstanding_q, outstanding_d;
    logic            discard_q, discard_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    // Queue storage: one {pc, word} pair per entry
    logic [XLEN-1:0]   pc_mem   [DEPTH];
    logic [IWIDTH-1:0] word_mem [DEPTH];

    logic req_fire, rsp_fire, flush, push, pop;
    logic [XLEN-1:0] flush_pc;

    // The low two bits of a redirect target are dropped by alignment.
    logic unused_align;
    assign unused_align = ^redirect_pc[1:0];

    assign imem_req_valid = run_q & ~outstanding_q & (count_q < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign inst_valid     = (count_q != '0);
    assign inst_data      = word_mem[head_q];
    assign inst_pc        = pc_mem[head_q];
    assign pc_out         = fetch_pc_q;
    assign occupancy      = count_q;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign rsp_fire = imem_rsp_valid & outstanding_q;
    assign flush    = clr | redirect;
    assign flush_pc = clr ? RESET_PC : {redirect_pc[XLEN-1:2], 2'b00};
    // A flush in the same cycle kills both the incoming word and any pop.
    assign push     = rsp_fire & ~discard_q & ~flush;
    assign pop      = inst_valid & inst_ready & ~flush;

    // Next-state: request tracking, fetch PC and queue pointers
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;

        if (req_fire) begin
            outstanding_d = 1'b1;
            req_pc_d      = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
        end else if (rsp_fire) begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
        end

        if (flush) begin
            fetch_pc_d = flush_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            // Anything still owed by memory after this edge is now stale.
            if (req_fire || (outstanding_q && !imem_rsp_valid)) begin
                outstanding_d = 1'b1;
                discard_d     = 1'b1;
            end
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            if (push && !pop)
                count_d = count_q + CW'(1);
            else if (!push && pop)
                count_d = count_q - CW'(1);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            run_q         <= 1'b0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            run_q         <= 1'b1;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Per-entry write of returned words; storage needs no reset because
    // count gates visibility of every entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (tail_q == PW'(gi))) begin
                    pc_mem[gi]   <= req_pc_q;
                    word_mem[gi] <= imem_rsp_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit against a behavioural instruction memory
// with configurable latency/backpressure. The expected instruction stream is
// the sequential address sequence from the latest restart point (reset, clr
// or redirect); a monitor pops it as decode accepts words.
module tb_fetch_unit;

    localparam int          XLEN     = 32;
    localparam int          IWIDTH   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] pc_out;
    logic [2:0]  occupancy;

    fetch_unit #(.XLEN(XLEN), .IWIDTH(IWIDTH), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .clr(clr), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .pc_out(pc_out), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];

    int checks = 0;
    int errors = 0;
    int n_pop = 0;
    int req_cnt = 0;
    int cyc = 0;
    int last_req_cyc = 0;
    bit last_req_seen = 0;
    logic [31:0] last_req_addr = '0;
    bit gap_check = 0;
    bit rand_ready = 0;
    bit rand_lat = 0;
    int fixed_lat = 1;

    exp_t  mon_e;
    pend_t mem_p;

    // Memory contents: odd multiplier makes every address map to a distinct word.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    // Expected stream: sequential aligned words from the restart address.
    task automatic restart(input logic [31:0] pc);
        logic [31:0] a;
        exp_t e;
        exp_q.delete();
        a = {pc[31:2], 2'b00};
        for (int i = 0; i < 1024; i++) begin
            e.pc = a;
            e.data = memword(a);
            exp_q.push_back(e);
            a = a + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int n, input string name);
        int target;
        target = n_pop + n;
        for (int i = 0; i < 400 && n_pop < target; i++) tick();
        if (n_pop < target) timeout(name);
    endtask

    task automatic wait_req(input string name);
        int base;
        base = req_cnt;
        for (int i = 0; i < 50 && req_cnt == base; i++) tick();
        if (req_cnt == base) timeout(name);
    endtask

    // Instruction memory model: sets this cycle's inputs mid-cycle, then
    // records any request handshake that will complete at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            pend_q.delete();
            imem_rsp_valid = 1'b0;
            last_req_seen = 0;
        end else begin
            cyc++;
            imem_req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                mem_p = pend_q.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memword(mem_p.addr);
            end
            if (imem_req_valid && imem_req_ready) begin
                mem_p.addr = imem_req_addr;
                mem_p.due  = cyc + (rand_lat ? int'($urandom_range(1, 4)) : fixed_lat);
                pend_q.push_back(mem_p);
                if (gap_check && last_req_seen) check("issue_gap", 32'(cyc - last_req_cyc), 32'd2);
                last_req_cyc  = cyc;
                last_req_seen = 1;
                last_req_addr = imem_req_addr;
                req_cnt++;
            end
        end
    end

    // Scoreboard monitor: every word decode accepts must be next in the stream.
    always @(negedge clk) begin
        if (rst && inst_valid && inst_ready && !clr && !redirect) begin
            if (exp_q.size() == 0) begin
                timeout("expected_stream_empty");
            end else begin
                mon_e = exp_q.pop_front();
                check("inst_pc", inst_pc, mon_e.pc);
                check("inst_data", inst_data, mon_e.data);
                $display("POP pc=%h data=%h", inst_pc, inst_data);
                n_pop++;
            end
        end
    end

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_pc_out", pc_out, RESET_PC);
        check("rst_req_valid", 32'(imem_req_valid), 0);
        check("rst_inst_valid", 32'(inst_valid), 0);
        check("rst_occupancy", 32'(occupancy), 0);

        // Streaming, 1-cycle memory: one request every two cycles
        fixed_lat = 1;
        inst_ready = 1'b1;
        restart(RESET_PC);
        rst = 1'b1;
        check("release_req_valid", 32'(imem_req_valid), 0);
        tick();
        check("first_req_valid", 32'(imem_req_valid), 1);
        check("first_req_addr", imem_req_addr, RESET_PC);
        gap_check = 1;
        wait_pops(10, "stream_pops");
        gap_check = 0;

        // Backpressure fills the queue and stalls fetch
        inst_ready = 1'b0;
        for (int i = 0; i < 60 && occupancy != 3'd4; i++) tick();
        repeat (4) tick();
        check("full_occupancy", 32'(occupancy), 4);
        check("full_req_valid", 32'(imem_req_valid), 0);
        check("full_next_addr", imem_req_addr, exp_q[0].pc + 32'd16);
        inst_ready = 1'b1;
        wait_pops(6, "drain_pops");

        // Redirect while a 3-cycle request is in flight
        fixed_lat = 3;
        wait_req("redir_issue");
        redirect = 1'b1;
        redirect_pc = 32'h103;
        restart(32'h103);
        tick();
        redirect = 1'b0;
        check("redir_inst_valid", 32'(inst_valid), 0);
        check("redir_pc_out", pc_out, 32'h100);
        wait_req("redir_next_req");
        check("redir_req_addr", last_req_addr, 32'h100);
        wait_pops(4, "redir_pops");

        // clr and redirect together with two words queued
        fixed_lat = 1;
        inst_ready = 1'b0;
        for (int i = 0; i < 60 && occupancy != 3'd2; i++) tick();
        check("pre_flush_occ", 32'(occupancy), 2);
        clr = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        restart(RESET_PC);
        tick();
        clr = 1'b0;
        redirect = 1'b0;
        check("flush_occupancy", 32'(occupancy), 0);
        check("flush_pc_out", pc_out, RESET_PC);
        check("flush_inst_valid", 32'(inst_valid), 0);
        inst_ready = 1'b1;
        wait_pops(3, "flush_pops");

        // Fetch PC wraps past the top of the address space
        redirect = 1'b1;
        redirect_pc = 32'hFFFFFFFC;
        restart(32'hFFFFFFFC);
        tick();
        redirect = 1'b0;
        check("wrap_pc_out", pc_out, 32'hFFFFFFFC);
        wait_req("wrap_req0");
        check("wrap_req0_addr", last_req_addr, 32'hFFFFFFFC);
        wait_req("wrap_req1");
        check("wrap_req1_addr", last_req_addr, 32'h0);
        wait_pops(3, "wrap_pops");

        // Asynchronous reset with a request outstanding and words queued
        fixed_lat = 3;
        inst_ready = 1'b0;
        for (int i = 0; i < 60 && !(occupancy != 0 && pend_q.size() > 0); i++) tick();
        #3;
        rst = 1'b0;
        #1;
        check("arst_pc_out", pc_out, RESET_PC);
        check("arst_req_valid", 32'(imem_req_valid), 0);
        check("arst_inst_valid", 32'(inst_valid), 0);
        check("arst_occupancy", 32'(occupancy), 0);
        repeat (2) tick();
        restart(RESET_PC);
        rst = 1'b1;
        inst_ready = 1'b1;
        check("rerelease_req_valid", 32'(imem_req_valid), 0);
        tick();
        check("restart_req_valid", 32'(imem_req_valid), 1);
        check("restart_req_addr", imem_req_addr, RESET_PC);
        wait_pops(3, "restart_pops");

        // Random backpressure, latency, redirects and clears
        rand_ready = 1;
        rand_lat = 1;
        for (int i = 0; i < 800; i++) begin
            tick();
            redirect = 1'b0;
            clr = 1'b0;
            inst_ready = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 99))
                0, 1, 2, 3: begin
                    redirect = 1'b1;
                    redirect_pc = $urandom;
                    restart(redirect_pc);
                end
                4: begin
                    clr = 1'b1;
                    restart(RESET_PC);
                end
                5: begin
                    clr = 1'b1;
                    redirect = 1'b1;
                    redirect_pc = $urandom;
                    restart(RESET_PC);
                end
                default: ;
            endcase
        end
        tick();
        redirect = 1'b0;
        clr = 1'b0;
        rand_ready = 0;
        rand_lat = 0;
        fixed_lat = 1;
        inst_ready = 1'b1;
        wait_pops(4, "final_pops");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
